minmax_seq_ctrl: RTL and testbench

//  Sequencer sharing one external combinational 4-bit magnitude comparator (altb/agtb/aeqb)
//  to find the max and min of a burst of COUNT unsigned samples.

---
 rtl/minmax_seq_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_minmax_seq_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/minmax_seq_ctrl.sv
// minmax_seq_ctrl: finds the max and min of a burst of COUNT unsigned samples by
// time-multiplexing one external magnitude comparator. Each later sample is compared
// against the running max, then against the running min. The comparator results alone
// decide the updates. All outputs come straight from flops.
module minmax_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int COUNT = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] comp_a,
  output logic [WIDTH-1:0] comp_b,
  input  logic             altb,
  input  logic             agtb,
  input  logic             aeqb,
  output logic [WIDTH-1:0] max_out,
  output logic [WIDTH-1:0] min_out,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             busy,
  output logic             done,
  output logic             cmp_err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_IN = 3'd1,
    S_CMP_MAX = 3'd2,
    S_CMP_MIN = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] COUNT_C = CNT_W'(COUNT);

  // A healthy comparator asserts exactly one of its three result lines.
  function automatic logic is_onehot3(input logic [2:0] v);
    logic r;
    case (v)
      3'b001, 3'b010, 3'b100: r = 1'b1;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cmp_err_q, cmp_err_d;
  logic [WIDTH-1:0] max_out_q, max_out_d;
  logic [WIDTH-1:0] min_out_q, min_out_d;
  logic [WIDTH-1:0] sample_reg_q, sample_reg_d;
  logic [WIDTH-1:0] comp_a_q, comp_a_d;
  logic [WIDTH-1:0] comp_b_q, comp_b_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic             accept_s;
  logic             res_ok_s;

  assign accept_s = in_valid & in_ready_q;
  assign res_ok_s = is_onehot3({altb, agtb, aeqb});

  // Next-state and datapath updates; output flops are loaded from the next state so
  // that they line up with the state they describe.
  always_comb begin
    state_d      = state_q;
    cmp_err_d    = cmp_err_q;
    max_out_d    = max_out_q;
    min_out_d    = min_out_q;
    sample_reg_d = sample_reg_q;
    sample_cnt_d = sample_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_WAIT_IN;
          sample_cnt_d = '0;
          cmp_err_d    = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_IN: begin
        if (accept_s) begin
          if (sample_cnt_q == '0) begin
            max_out_d    = in_data;
            min_out_d    = in_data;
            sample_cnt_d = CNT_W'(1);
            state_d      = (COUNT == 1) ? S_DONE : S_WAIT_IN;
          end else begin
            sample_reg_d = in_data;
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
            state_d      = S_CMP_MAX;
          end
        end else begin
          state_d = S_WAIT_IN;
        end
      end
      S_CMP_MAX: begin
        if (agtb) begin
          max_out_d = sample_reg_q;
        end else begin
          max_out_d = max_out_q;
        end
        if (!res_ok_s) begin
          cmp_err_d = 1'b1;
        end else begin
          cmp_err_d = cmp_err_q;
        end
        state_d = S_CMP_MIN;
      end
      S_CMP_MIN: begin
        if (altb) begin
          min_out_d = sample_reg_q;
        end else begin
          min_out_d = min_out_q;
        end
        if (!res_ok_s) begin
          cmp_err_d = 1'b1;
        end else begin
          cmp_err_d = cmp_err_q;
        end
        if (sample_cnt_q == COUNT_C) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT_IN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output flop inputs decoded from the state being entered.
  always_comb begin
    in_ready_d = (state_d == S_WAIT_IN);
    busy_d     = (state_d == S_WAIT_IN) || (state_d == S_CMP_MAX) || (state_d == S_CMP_MIN);
    done_d     = (state_d == S_DONE);
    comp_a_d   = comp_a_q;
    comp_b_d   = comp_b_q;
    case (state_d)
      S_CMP_MAX: begin
        comp_a_d = sample_reg_d;
        comp_b_d = max_out_d;
      end
      S_CMP_MIN: begin
        comp_a_d = sample_reg_d;
        comp_b_d = min_out_d;
      end
      default: begin
        comp_a_d = comp_a_q;
        comp_b_d = comp_b_q;
      end
    endcase
  end

  // State and output registers with synchronous reset; reset abandons any burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cmp_err_q    <= 1'b0;
      max_out_q    <= '0;
      min_out_q    <= '0;
      sample_reg_q <= '0;
      comp_a_q     <= '0;
      comp_b_q     <= '0;
      sample_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cmp_err_q    <= cmp_err_d;
      max_out_q    <= max_out_d;
      min_out_q    <= min_out_d;
      sample_reg_q <= sample_reg_d;
      comp_a_q     <= comp_a_d;
      comp_b_q     <= comp_b_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cmp_err    = cmp_err_q;
  assign max_out    = max_out_q;
  assign min_out    = min_out_q;
  assign comp_a     = comp_a_q;
  assign comp_b     = comp_b_q;
  assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_minmax_seq_ctrl.sv
// Testbench for minmax_seq_ctrl: a COUNT=8 instance driven from a burst table plus
// hand sequences (reset mid-burst), and a COUNT=1 instance for the single-sample case.
module tb_minmax_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  // COUNT=8 instance
  logic       start, in_valid, in_ready, altb, agtb, aeqb, busy, done, cmp_err;
  logic [3:0] in_data, comp_a, comp_b, max_out, min_out, sample_cnt;
  logic       force_both;
  // COUNT=1 instance
  logic       start2, in_valid2, in_ready2, altb2, agtb2, aeqb2, busy2, done2, cmp_err2;
  logic [3:0] in_data2, comp_a2, comp_b2, max_out2, min_out2, sample_cnt2;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  // Comparator model; force_both drives an illegal altb=agtb=1 result.
  assign altb  = (comp_a < comp_b) | force_both;
  assign agtb  = (comp_a > comp_b) | force_both;
  assign aeqb  = (comp_a == comp_b) & ~force_both;
  assign altb2 = (comp_a2 < comp_b2);
  assign agtb2 = (comp_a2 > comp_b2);
  assign aeqb2 = (comp_a2 == comp_b2);

  minmax_seq_ctrl #(.WIDTH(4), .COUNT(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .comp_a(comp_a), .comp_b(comp_b), .altb(altb), .agtb(agtb),
    .aeqb(aeqb), .max_out(max_out), .min_out(min_out), .sample_cnt(sample_cnt),
    .busy(busy), .done(done), .cmp_err(cmp_err)
  );

  minmax_seq_ctrl #(.WIDTH(4), .COUNT(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid2), .in_data(in_data2),
    .in_ready(in_ready2), .comp_a(comp_a2), .comp_b(comp_b2), .altb(altb2), .agtb(agtb2),
    .aeqb(aeqb2), .max_out(max_out2), .min_out(min_out2), .sample_cnt(sample_cnt2),
    .busy(busy2), .done(done2), .cmp_err(cmp_err2)
  );

  // Count done pulses of the COUNT=8 instance.
  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  typedef struct {
    logic [7:0][3:0] s;
    bit              gap;
    bit              hold_start;
    int              force_idx;
    int              emax;
    int              emin;
    int              eerr;
  } vec_t;

  vec_t tbl[6];

  function automatic logic [7:0][3:0] mk(input int a0, input int a1, input int a2,
                                         input int a3, input int a4, input int a5,
                                         input int a6, input int a7);
    logic [7:0][3:0] r;
    r[0] = 4'(a0); r[1] = 4'(a1); r[2] = 4'(a2); r[3] = 4'(a3);
    r[4] = 4'(a4); r[5] = 4'(a5); r[6] = 4'(a6); r[7] = 4'(a7);
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_burst(input vec_t v, input string tag);
    int n;
    int lat;
    int d0;
    int exp_lat;
    d0 = done_cnt;
    start = 1'b1;
    step();
    if (!v.hold_start) start = 1'b0;
    chk({tag, " busy_after_start"}, busy, 1);
    chk({tag, " ready_after_start"}, in_ready, 1);
    chk({tag, " cnt_cleared"}, sample_cnt, 0);
    chk({tag, " err_cleared"}, cmp_err, 0);
    for (int i = 0; i < 8; i++) begin
      in_valid = !v.gap;
      in_data  = v.s[i];
      n = 0;
      while (!in_ready && n < 20) begin
        step();
        n++;
      end
      chk({tag, " ready_wait"}, in_ready, 1);
      if (v.gap) begin
        step();
        chk({tag, " bubble_no_accept"}, sample_cnt, i);
      end
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      if (i == v.force_idx) begin
        force_both = 1'b1;
        step();
        force_both = 1'b0;
      end
    end
    exp_lat = (v.force_idx == 7) ? 1 : 2;
    lat = 0;
    while (!done && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, " done_latency"}, lat, exp_lat);
    chk({tag, " done"}, done, 1);
    chk({tag, " busy_in_done"}, busy, 0);
    chk({tag, " max"}, max_out, v.emax);
    chk({tag, " min"}, min_out, v.emin);
    chk({tag, " cnt"}, sample_cnt, 8);
    chk({tag, " cmp_err"}, cmp_err, v.eerr);
    step();
    start = 1'b0;
    chk({tag, " done_pulse_end"}, done, 0);
    chk({tag, " idle_not_ready"}, in_ready, 0);
    chk({tag, " done_count"}, done_cnt - d0, 1);
    step();
    chk({tag, " no_second_burst"}, busy, 0);
    chk({tag, " max_hold"}, max_out, v.emax);
    chk({tag, " min_hold"}, min_out, v.emin);
    chk({tag, " err_hold"}, cmp_err, v.eerr);
  endtask

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 4'd0; force_both = 1'b0;
    start2 = 1'b0; in_valid2 = 1'b0; in_data2 = 4'd0;

    tbl[0] = '{mk(5, 7, 9, 3, 8, 8, 0, 15), 1'b0, 1'b0, -1, 15, 0, 0};
    tbl[1] = '{mk(8, 8, 8, 8, 8, 8, 8, 8), 1'b0, 1'b0, -1, 8, 8, 0};
    tbl[2] = '{mk(5, 7, 9, 3, 8, 8, 0, 15), 1'b1, 1'b1, -1, 15, 0, 0};
    tbl[3] = '{mk(15, 14, 13, 12, 11, 10, 9, 8), 1'b0, 1'b0, -1, 15, 8, 0};
    tbl[4] = '{mk(3, 1, 4, 1, 5, 9, 2, 6), 1'b1, 1'b0, -1, 9, 1, 0};
    // Forced altb=agtb=1 on sample 2's max compare: max takes 2, then 5 wins.
    tbl[5] = '{mk(4, 2, 5, 5, 5, 5, 5, 5), 1'b0, 1'b0, 1, 5, 2, 1};

    step();
    step();
    chk("rst in_ready", in_ready, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst cmp_err", cmp_err, 0);
    chk("rst max", max_out, 0);
    chk("rst min", min_out, 0);
    chk("rst cnt", sample_cnt, 0);
    chk("rst comp_a", comp_a, 0);
    chk("rst comp_b", comp_b, 0);
    rst = 1'b0;
    step();

    for (int t = 0; t < 6; t++) begin
      run_burst(tbl[t], $sformatf("vec%0d", t));
    end

    // Sticky error survives into IDLE and is cleared by the next accepted start.
    chk("err_sticky_idle", cmp_err, 1);

    // Reset during CMP_MIN of the 4th sample.
    d0 = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t4 err_cleared_by_start", cmp_err, 0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 4'(i + 1);
      for (int n = 0; n < 20 && !in_ready; n++) step();
      step();
    end
    in_valid = 1'b0;
    chk("t4 cmpmax comp_a", comp_a, 4);
    chk("t4 cmpmax comp_b", comp_b, 3);
    step();
    chk("t4 cmpmin comp_a", comp_a, 4);
    chk("t4 cmpmin comp_b", comp_b, 1);
    chk("t4 max_before_rst", max_out, 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t4 in_ready", in_ready, 0);
    chk("t4 busy", busy, 0);
    chk("t4 done", done, 0);
    chk("t4 max", max_out, 0);
    chk("t4 min", min_out, 0);
    chk("t4 cnt", sample_cnt, 0);
    chk("t4 comp_a", comp_a, 0);
    chk("t4 comp_b", comp_b, 0);
    step();
    chk("t4 stays_idle", busy, 0);
    chk("t4 no_done", done_cnt - d0, 0);
    run_burst(tbl[0], "t4_fresh");

    // COUNT=1 instance: single sample 6.
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    chk("t6 busy", busy2, 1);
    chk("t6 ready", in_ready2, 1);
    in_valid2 = 1'b1;
    in_data2  = 4'd6;
    step();
    in_valid2 = 1'b0;
    chk("t6 done", done2, 1);
    chk("t6 max", max_out2, 6);
    chk("t6 min", min_out2, 6);
    chk("t6 cnt", sample_cnt2, 1);
    chk("t6 busy_in_done", busy2, 0);
    step();
    chk("t6 done_pulse_end", done2, 0);
    chk("t6 idle", in_ready2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
